// File: rtl/wormhole_alloc.sv
// Per-output wormhole switch allocator: round-robin head arbitration per output,
// with each output held by its winning input until that input's tail flit transfers.
module wormhole_alloc #(
  parameter  int PORTS = 4,
  localparam int LOG   = $clog2(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req_valid,
  input  logic [LOG-1:0]   req_dest [PORTS],
  input  logic [PORTS-1:0] req_last,
  input  logic [PORTS-1:0] out_ready,
  output logic [PORTS-1:0] grant,
  output logic [LOG-1:0]   sel [PORTS],
  output logic [PORTS-1:0] sel_valid,
  output logic [PORTS-1:0] locked
);

  logic [PORTS-1:0] lock_q;
  logic [LOG-1:0]   owner_q [PORTS];
  logic [LOG-1:0]   ptr_q [PORTS];
  logic [PORTS-1:0] in_lock_q;
  logic [LOG-1:0]   in_out_q [PORTS];

  logic [LOG-1:0]   eff_dest [PORTS];
  logic [PORTS-1:0] xfer;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      eff_dest[i] = in_lock_q[i] ? in_out_q[i] : req_dest[i];
    end
  end

  // The round-robin scan runs from the far end back toward ptr so that the
  // last match written is the first candidate in priority order.
  always_comb begin
    logic [LOG:0]   sum;
    logic [LOG-1:0] idx;
    grant     = '0;
    sel_valid = '0;
    xfer      = '0;
    sum       = '0;
    idx       = '0;
    for (int o = 0; o < PORTS; o++) begin
      sel[o] = '0;
    end
    if (!rst) begin
      for (int o = 0; o < PORTS; o++) begin
        if (lock_q[o]) begin
          sel[o]       = owner_q[o];
          sel_valid[o] = req_valid[owner_q[o]];
        end else begin
          for (int k = PORTS - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q[o]} + (LOG+1)'(k);
            if (sum >= (LOG+1)'(PORTS)) begin
              sum = sum - (LOG+1)'(PORTS);
            end
            idx = sum[LOG-1:0];
            if (req_valid[idx] && !in_lock_q[idx] && eff_dest[idx] == LOG'(o)) begin
              sel[o]       = idx;
              sel_valid[o] = 1'b1;
            end
          end
        end
        xfer[o] = sel_valid[o] & out_ready[o];
        if (xfer[o]) begin
          grant[sel[o]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= '0;
      in_lock_q <= '0;
      for (int i = 0; i < PORTS; i++) begin
        owner_q[i]  <= '0;
        ptr_q[i]    <= '0;
        in_out_q[i] <= '0;
      end
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        if (xfer[o]) begin
          if (!lock_q[o]) begin
            ptr_q[o] <= (sel[o] == LOG'(PORTS - 1)) ? '0 : sel[o] + 1'b1;
            if (!req_last[sel[o]]) begin
              lock_q[o]           <= 1'b1;
              owner_q[o]          <= sel[o];
              in_lock_q[sel[o]]   <= 1'b1;
              in_out_q[sel[o]]    <= LOG'(o);
            end
          end else if (req_last[owner_q[o]]) begin
            lock_q[o]             <= 1'b0;
            in_lock_q[owner_q[o]] <= 1'b0;
          end
        end
      end
    end
  end

  assign locked = lock_q;

endmodule

// File: tb/tb_wormhole_alloc.sv
// Directed bench for wormhole_alloc (PORTS=4): arbitration order, packet locking,
// backpressure, owner bubbles, parallel outputs and asynchronous reset.
module tb_wormhole_alloc;
  localparam int PORTS = 4;
  localparam int LOG   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PORTS-1:0] req_valid;
  logic [LOG-1:0]   req_dest [PORTS];
  logic [PORTS-1:0] req_last;
  logic [PORTS-1:0] out_ready;
  logic [PORTS-1:0] grant;
  logic [LOG-1:0]   sel [PORTS];
  logic [PORTS-1:0] sel_valid;
  logic [PORTS-1:0] locked;

  int n_checks = 0;
  int n_fail   = 0;

  wormhole_alloc #(.PORTS(PORTS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dest(req_dest),
    .req_last(req_last), .out_ready(out_ready), .grant(grant), .sel(sel),
    .sel_valid(sel_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_last  = '0;
    out_ready = '0;
    for (int i = 0; i < PORTS; i++) req_dest[i] = '0;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    out_ready = 4'b1111;
    for (int i = 0; i < PORTS; i++) req_dest[i] = 2'd0;
    #2;
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_grant: got %b want 0000", grant); end
    n_checks++;
    if (sel_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_sel_valid: got %b want 0000", sel_valid); end
    n_checks++;
    if (sel[0] !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_sel0: got %0d want 0", sel[0]); end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    #2;
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("[TB] FAIL idle_grant: got %b want 0000", grant); end
    n_checks++;
    if (sel_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL idle_sel_valid: got %b want 0000", sel_valid); end
    n_checks++;
    if (locked !== 4'b0000) begin n_fail++; $display("[TB] FAIL idle_locked: got %b want 0000", locked); end
    for (int o = 0; o < PORTS; o++) begin
      n_checks++;
      if (dut.ptr_q[o] !== 2'd0) begin n_fail++; $display("[TB] FAIL idle_ptr%0d: got %0d want 0", o, dut.ptr_q[o]); end
    end
    next_cycle();
  endtask

  task automatic test_single_flit();
    logic [PORTS-1:0] exp_grant [3];
    exp_grant[0] = 4'b0001;
    exp_grant[1] = 4'b0010;
    exp_grant[2] = 4'b0100;
    req_valid = 4'b0111;
    req_last  = 4'b0111;
    out_ready = 4'b1000;
    for (int i = 0; i < 3; i++) req_dest[i] = 2'd3;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++;
      if (grant !== exp_grant[c]) begin n_fail++; $display("[TB] FAIL single_grant c%0d: got %b want %b", c, grant, exp_grant[c]); end
      n_checks++;
      if (sel[3] !== LOG'(c)) begin n_fail++; $display("[TB] FAIL single_sel3 c%0d: got %0d want %0d", c, sel[3], c); end
      n_checks++;
      if (locked[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL single_locked3 c%0d: got %b want 0", c, locked[3]); end
      next_cycle();
    end
    n_checks++;
    if (dut.ptr_q[3] !== 2'd3) begin n_fail++; $display("[TB] FAIL single_ptr3: got %0d want 3", dut.ptr_q[3]); end
    clear_inputs();
  endtask

  task automatic test_wormhole();
    logic [PORTS-1:0] exp_locked [4];
    exp_locked[0] = 4'b0000;
    exp_locked[1] = 4'b0100;
    exp_locked[2] = 4'b0100;
    exp_locked[3] = 4'b0000;
    out_ready = 4'b0100;
    req_dest[0] = 2'd2;
    req_dest[1] = 2'd2;
    for (int c = 0; c < 4; c++) begin
      req_valid = {2'b00, (c < 3), (c >= 1)};
      req_last  = {2'b00, (c == 2), 1'b1};
      #2;
      n_checks++;
      if (grant !== ((c < 3) ? 4'b0010 : 4'b0001)) begin n_fail++; $display("[TB] FAIL worm_grant c%0d: got %b", c, grant); end
      n_checks++;
      if (locked !== exp_locked[c]) begin n_fail++; $display("[TB] FAIL worm_locked c%0d: got %b want %b", c, locked, exp_locked[c]); end
      n_checks++;
      if (sel[2] !== ((c < 3) ? 2'd1 : 2'd0)) begin n_fail++; $display("[TB] FAIL worm_sel2 c%0d: got %0d", c, sel[2]); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    // ptr[2] is 1 here; input 2 owns output 2 while input 3 contends.
    logic [PORTS-1:0] v [6], rdy [6], last [6], g [6], sv [6], lk [6];
    logic [LOG-1:0]   s2 [6];
    v[0]=4'b1100; rdy[0]=4'b0100; last[0]=4'b1000; g[0]=4'b0100; sv[0]=4'b0100; lk[0]=4'b0000; s2[0]=2'd2;
    v[1]=4'b1100; rdy[1]=4'b0000; last[1]=4'b1000; g[1]=4'b0000; sv[1]=4'b0100; lk[1]=4'b0100; s2[1]=2'd2;
    v[2]=4'b1100; rdy[2]=4'b0000; last[2]=4'b1000; g[2]=4'b0000; sv[2]=4'b0100; lk[2]=4'b0100; s2[2]=2'd2;
    v[3]=4'b1000; rdy[3]=4'b0100; last[3]=4'b1000; g[3]=4'b0000; sv[3]=4'b0000; lk[3]=4'b0100; s2[3]=2'd2;
    v[4]=4'b1100; rdy[4]=4'b0100; last[4]=4'b1100; g[4]=4'b0100; sv[4]=4'b0100; lk[4]=4'b0100; s2[4]=2'd2;
    v[5]=4'b1000; rdy[5]=4'b0100; last[5]=4'b1000; g[5]=4'b1000; sv[5]=4'b0100; lk[5]=4'b0000; s2[5]=2'd3;
    req_dest[2] = 2'd2;
    req_dest[3] = 2'd2;
    for (int c = 0; c < 6; c++) begin
      req_valid = v[c];
      out_ready = rdy[c];
      req_last  = last[c];
      #2;
      n_checks++;
      if (grant !== g[c]) begin n_fail++; $display("[TB] FAIL bp_grant c%0d: got %b want %b", c, grant, g[c]); end
      n_checks++;
      if (sel_valid !== sv[c]) begin n_fail++; $display("[TB] FAIL bp_sel_valid c%0d: got %b want %b", c, sel_valid, sv[c]); end
      n_checks++;
      if (locked !== lk[c]) begin n_fail++; $display("[TB] FAIL bp_locked c%0d: got %b want %b", c, locked, lk[c]); end
      n_checks++;
      if (sel[2] !== s2[c]) begin n_fail++; $display("[TB] FAIL bp_sel2 c%0d: got %0d want %0d", c, sel[2], s2[c]); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_parallel();
    req_valid   = 4'b1001;
    req_last    = 4'b1001;
    out_ready   = 4'b1111;
    req_dest[0] = 2'd1;
    req_dest[3] = 2'd0;
    #2;
    n_checks++;
    if (grant !== 4'b1001) begin n_fail++; $display("[TB] FAIL par_grant: got %b want 1001", grant); end
    n_checks++;
    if (sel_valid !== 4'b0011) begin n_fail++; $display("[TB] FAIL par_sel_valid: got %b want 0011", sel_valid); end
    n_checks++;
    if (sel[0] !== 2'd3 || sel[1] !== 2'd0) begin n_fail++; $display("[TB] FAIL par_sel: got %0d/%0d want 3/0", sel[0], sel[1]); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    req_valid   = 4'b0010;
    req_last    = 4'b0000;
    out_ready   = 4'b0100;
    req_dest[1] = 2'd2;
    #2;
    n_checks++;
    if (grant !== 4'b0010) begin n_fail++; $display("[TB] FAIL rmid_head_grant: got %b want 0010", grant); end
    next_cycle();
    #2;
    n_checks++;
    if (locked !== 4'b0100) begin n_fail++; $display("[TB] FAIL rmid_locked_before: got %b want 0100", locked); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (locked !== 4'b0000) begin n_fail++; $display("[TB] FAIL rmid_locked_async: got %b want 0000", locked); end
    n_checks++;
    if (grant !== 4'b0000 || sel_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL rmid_outputs_async: grant %b sel_valid %b want 0000", grant, sel_valid); end
    n_checks++;
    if (sel[2] !== 2'd0) begin n_fail++; $display("[TB] FAIL rmid_sel2_async: got %0d want 0", sel[2]); end
    #1;
    rst = 1'b0;
    req_valid   = 4'b1001;
    req_dest[0] = 2'd2;
    req_dest[3] = 2'd2;
    #2;
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("[TB] FAIL rmid_regrant: got %b want 0001", grant); end
    n_checks++;
    if (sel[2] !== 2'd0) begin n_fail++; $display("[TB] FAIL rmid_sel2: got %0d want 0", sel[2]); end
    next_cycle();
    #2;
    n_checks++;
    if (locked !== 4'b0100 || grant !== 4'b0001) begin n_fail++; $display("[TB] FAIL rmid_relock: locked %b grant %b want 0100/0001", locked, grant); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_flit();
    test_wormhole();
    test_backpressure();
    test_parallel();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
